dl11_fifo_bridge: RTL and testbench

Multi-channel DL11-compatible console bridge between the DCJ11 I/O page and the Apple II slot.
- Generalises the single-byte RCSR/RBUF/XCSR/XBUF mailbox to NCH channels, each with DEPTH-entry TX and RX FIFOs.
- Adds RIE/XIE interrupt enables, RX overrun reporting and host-side flush/level status.
- Both sides arrive as single-cycle, already-synchronised strobes in the clk domain. Bus decode and CDC are external.

---
 rtl/dl11_fifo_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_dl11_fifo_bridge.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl11_fifo_bridge.sv
// Multi-channel DL11 console bridge. Each channel has a TX and an RX FIFO between the DCJ11
// I/O page (RCSR/RBUF/XCSR/XBUF) and a four-register Apple II slot window.
module dl11_fifo_bridge #(
  parameter int          NCH      = 2,
  parameter int          DEPTH    = 8,
  parameter logic [21:0] BASE0    = 22'o17777560,
  parameter logic [21:0] ALT_BASE = 22'o17776500
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [21:0]    cpu_addr,
  input  logic           cpu_rd,
  input  logic           cpu_wr,
  input  logic           cpu_byte,
  input  logic [15:0]    cpu_wdata,
  output logic [15:0]    cpu_rdata,
  output logic           cpu_hit,
  input  logic           cpu_init,
  output logic [NCH-1:0] rx_irq,
  output logic [NCH-1:0] tx_irq,
  input  logic [7:0]     host_addr,
  input  logic           host_rd,
  input  logic           host_wr,
  input  logic [7:0]     host_wdata,
  output logic [7:0]     host_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [7:0]    ID_VAL   = {4'(NCH - 1), 4'(AW)};
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

  logic [1:0]     cpu_reg;
  logic           cpu_lo_wr;
  logic [5:0]     host_ch;
  logic [1:0]     host_reg;
  logic           host_ch_ok;
  logic [NCH-1:0] cpu_sel;
  logic [NCH-1:0] host_sel;
  logic [15:0]    cpu_val [NCH];
  logic [7:0]     host_val [NCH];
  logic [15:0]    cpu_mux;
  logic [7:0]     host_mux;
  logic [15:0]    cpu_rdata_reg;
  logic [7:0]     host_rdata_reg;
  logic           unused_bits;

  assign cpu_reg     = cpu_addr[2:1];
  // a byte access with addr[0]=1 targets the high byte, which holds nothing writable
  assign cpu_lo_wr   = !(cpu_byte && cpu_addr[0]);
  assign host_ch     = host_addr[7:2];
  assign host_reg    = host_addr[1:0];
  assign host_ch_ok  = 32'(host_ch) < NCH;
  assign unused_bits = &{1'b0, cpu_wdata[15:8], host_wdata[7:2]};

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    localparam logic [21:0] CH_BASE = (gi == 0) ? BASE0 : ALT_BASE + 22'(8 * (gi - 1));

    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] tx_wr_reg, tx_rd_reg, rx_wr_reg, rx_rd_reg;
    logic [PW-1:0] tx_cnt, rx_cnt;
    logic          tx_empty, tx_full, rx_empty, rx_full;
    logic          tx_push, tx_pop, tx_flush;
    logic          rx_push, rx_pop, rx_flush, rx_drop;
    logic          cpu_rd_ch, cpu_wr_ch, host_rd_ch, host_wr_ch;
    logic          rbuf_rd, rcsr_wr, xcsr_wr;
    logic          rie_reg, xie_reg, ovr_reg;
    logic          rx_irq_reg, tx_irq_reg;
    logic [7:0]    tx_cnt8;
    logic [4:0]    tx_occ;
    logic [15:0]   cpu_val_ch;
    logic [7:0]    host_val_ch;

    assign cpu_sel[gi]  = (cpu_addr[21:3] == CH_BASE[21:3]);
    assign host_sel[gi] = host_ch_ok && (host_ch == 6'(gi));
    assign cpu_rd_ch    = cpu_rd && cpu_sel[gi];
    assign cpu_wr_ch    = cpu_wr && cpu_sel[gi];
    assign host_rd_ch   = host_rd && host_sel[gi];
    assign host_wr_ch   = host_wr && host_sel[gi];

    assign tx_cnt   = tx_wr_reg - tx_rd_reg;
    assign rx_cnt   = rx_wr_reg - rx_rd_reg;
    assign tx_empty = (tx_cnt == '0);
    assign rx_empty = (rx_cnt == '0);
    assign tx_full  = (tx_cnt == FULL_CNT);
    assign rx_full  = (rx_cnt == FULL_CNT);

    assign rbuf_rd = cpu_rd_ch && (cpu_reg == 2'd1);
    assign rcsr_wr = cpu_wr_ch && (cpu_reg == 2'd0) && cpu_lo_wr;
    assign xcsr_wr = cpu_wr_ch && (cpu_reg == 2'd2) && cpu_lo_wr;

    // pops see only the pre-cycle state; a push into a full FIFO rides on a same-cycle pop
    assign rx_pop   = rbuf_rd && !rx_empty;
    assign tx_pop   = host_rd_ch && (host_reg == 2'd1) && !tx_empty;
    assign tx_push  = cpu_wr_ch && (cpu_reg == 2'd3) && cpu_lo_wr && (!tx_full || tx_pop);
    assign rx_push  = host_wr_ch && (host_reg == 2'd2) && (!rx_full || rx_pop);
    assign rx_drop  = host_wr_ch && (host_reg == 2'd2) && rx_full && !rx_pop;
    assign tx_flush = cpu_init || (host_wr_ch && (host_reg == 2'd0) && host_wdata[0]);
    assign rx_flush = cpu_init || (host_wr_ch && (host_reg == 2'd0) && host_wdata[1]);

    always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_reg[AW-1:0]] <= cpu_wdata[7:0];
      if (rx_push) rx_mem[rx_wr_reg[AW-1:0]] <= host_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tx_wr_reg  <= '0;
        tx_rd_reg  <= '0;
        rx_wr_reg  <= '0;
        rx_rd_reg  <= '0;
        rie_reg    <= 1'b0;
        xie_reg    <= 1'b0;
        ovr_reg    <= 1'b0;
        rx_irq_reg <= 1'b0;
        tx_irq_reg <= 1'b0;
      end else begin
        rx_irq_reg <= rie_reg && !rx_empty;
        tx_irq_reg <= xie_reg && !tx_full;
        if (tx_flush) begin
          tx_wr_reg <= '0;
          tx_rd_reg <= '0;
        end else begin
          if (tx_push) tx_wr_reg <= tx_wr_reg + PW'(1);
          if (tx_pop)  tx_rd_reg <= tx_rd_reg + PW'(1);
        end
        if (rx_flush) begin
          rx_wr_reg <= '0;
          rx_rd_reg <= '0;
        end else begin
          if (rx_push) rx_wr_reg <= rx_wr_reg + PW'(1);
          if (rx_pop)  rx_rd_reg <= rx_rd_reg + PW'(1);
        end
        if (cpu_init) begin
          rie_reg <= 1'b0;
          xie_reg <= 1'b0;
          ovr_reg <= 1'b0;
        end else begin
          if (rcsr_wr) rie_reg <= cpu_wdata[6];
          if (xcsr_wr) xie_reg <= cpu_wdata[6];
          // a fresh overrun outranks the acknowledge of an older one
          if (rx_drop)      ovr_reg <= 1'b1;
          else if (rbuf_rd) ovr_reg <= 1'b0;
        end
      end
    end

    assign tx_cnt8 = 8'(tx_cnt);
    assign tx_occ  = (tx_cnt8 > 8'd31) ? 5'd31 : tx_cnt8[4:0];

    always_comb begin
      cpu_val_ch = 16'h0000;
      case (cpu_reg)
        2'd0:    cpu_val_ch = {8'h00, !rx_empty, rie_reg, 6'h00};
        2'd1:    cpu_val_ch = {ovr_reg, ovr_reg, 6'h00,
                               rx_empty ? 8'h00 : rx_mem[rx_rd_reg[AW-1:0]]};
        2'd2:    cpu_val_ch = {8'h00, !tx_full, xie_reg, 6'h00};
        default: cpu_val_ch = 16'h0000;
      endcase
    end

    always_comb begin
      host_val_ch = 8'h00;
      case (host_reg)
        2'd0:    host_val_ch = {!tx_empty, !rx_full, ovr_reg, tx_occ};
        2'd1:    host_val_ch = tx_empty ? 8'h00 : tx_mem[tx_rd_reg[AW-1:0]];
        2'd3:    host_val_ch = ID_VAL;
        default: host_val_ch = 8'h00;
      endcase
    end

    assign cpu_val[gi]  = cpu_val_ch;
    assign host_val[gi] = host_val_ch;
    assign rx_irq[gi]   = rx_irq_reg;
    assign tx_irq[gi]   = tx_irq_reg;
  end

  assign cpu_hit = |cpu_sel;

  always_comb begin
    cpu_mux = 16'h0000;
    for (int i = 0; i < NCH; i++) begin
      if (cpu_sel[i]) cpu_mux = cpu_val[i];
    end
  end

  always_comb begin
    host_mux = 8'h00;
    for (int i = 0; i < NCH; i++) begin
      if (host_sel[i]) host_mux = host_val[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_reg  <= 16'h0000;
      host_rdata_reg <= 8'h00;
    end else begin
      if (cpu_rd)  cpu_rdata_reg  <= cpu_mux;
      if (host_rd) host_rdata_reg <= host_mux;
    end
  end

  assign cpu_rdata  = cpu_rdata_reg;
  assign host_rdata = host_rdata_reg;
endmodule

// File: tb/tb_dl11_fifo_bridge.sv
// Bench for dl11_fifo_bridge: queue-based channel model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_dl11_fifo_bridge;
  localparam int NCH   = 2;
  localparam int DEPTH = 8;
  localparam logic [21:0] BASE0    = 22'o17777560;
  localparam logic [21:0] ALT_BASE = 22'o17776500;
  localparam logic [21:0] RCSR0 = 22'o17777560;
  localparam logic [21:0] RBUF0 = 22'o17777562;
  localparam logic [21:0] XCSR0 = 22'o17777564;
  localparam logic [21:0] XBUF0 = 22'o17777566;
  localparam logic [21:0] RBUF1 = 22'o17776502;
  localparam logic [21:0] XBUF1 = 22'o17776506;
  localparam logic [7:0]  ID_EXP = {4'(NCH - 1), 4'($clog2(DEPTH))};

  logic           clk = 1'b0;
  logic           rst_n;
  logic [21:0]    cpu_addr;
  logic           cpu_rd, cpu_wr, cpu_byte, cpu_init;
  logic [15:0]    cpu_wdata;
  logic [15:0]    cpu_rdata;
  logic           cpu_hit;
  logic [NCH-1:0] rx_irq, tx_irq;
  logic [7:0]     host_addr, host_wdata, host_rdata;
  logic           host_rd, host_wr;

  dl11_fifo_bridge #(.NCH(NCH), .DEPTH(DEPTH), .BASE0(BASE0), .ALT_BASE(ALT_BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_byte(cpu_byte),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit), .cpu_init(cpu_init),
    .rx_irq(rx_irq), .tx_irq(tx_irq),
    .host_addr(host_addr), .host_rd(host_rd), .host_wr(host_wr),
    .host_wdata(host_wdata), .host_rdata(host_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  logic [7:0] tx_q [NCH][$];
  logic [7:0] rx_q [NCH][$];
  bit rie [NCH];
  bit xie [NCH];
  bit ovr [NCH];
  logic [15:0]    exp_cpu_rdata;
  logic [7:0]     exp_host_rdata;
  logic [NCH-1:0] exp_rx_irq, exp_tx_irq;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int cpu_chan(input logic [21:0] a);
    int ai;
    int base;
    ai = int'(a);
    if (ai >= int'(BASE0) && ai <= int'(BASE0) + 7) return 0;
    for (int n = 1; n < NCH; n++) begin
      base = int'(ALT_BASE) + 8 * (n - 1);
      if (ai >= base && ai <= base + 7) return n;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cpu_rdata", cpu_rdata, exp_cpu_rdata);
      chk("host_rdata", 16'(host_rdata), 16'(exp_host_rdata));
      chk("rx_irq", 16'(rx_irq), 16'(exp_rx_irq));
      chk("tx_irq", 16'(tx_irq), 16'(exp_tx_irq));
      chk("cpu_hit", 16'(cpu_hit), 16'(cpu_chan(cpu_addr) >= 0));
    end
  end

  // One clock of stimulus: reads see the pre-cycle state, pops free space before pushes,
  // flushes and INIT override everything else.
  task automatic step();
    int cc, hc, occ;
    logic [1:0] cr, hr;
    logic [15:0] n_cpu;
    logic [7:0] n_host;
    logic [NCH-1:0] n_rxi, n_txi;
    bit tx_fl, rx_fl;
    cc = cpu_chan(cpu_addr);
    cr = cpu_addr[2:1];
    hc = int'(host_addr[7:2]);
    hr = host_addr[1:0];
    if (hc >= NCH) hc = -1;
    for (int n = 0; n < NCH; n++) begin
      n_rxi[n] = rie[n] && (rx_q[n].size() != 0);
      n_txi[n] = xie[n] && (tx_q[n].size() < DEPTH);
    end
    n_cpu  = exp_cpu_rdata;
    n_host = exp_host_rdata;
    if (cpu_rd) begin
      n_cpu = 16'h0000;
      if (cc >= 0) begin
        case (cr)
          2'd0: n_cpu = {8'h00, rx_q[cc].size() != 0, rie[cc], 6'h00};
          2'd1: n_cpu = {ovr[cc], ovr[cc], 6'h00, (rx_q[cc].size() != 0) ? rx_q[cc][0] : 8'h00};
          2'd2: n_cpu = {8'h00, tx_q[cc].size() < DEPTH, xie[cc], 6'h00};
          default: n_cpu = 16'h0000;
        endcase
      end
    end
    if (host_rd) begin
      n_host = 8'h00;
      if (hc >= 0) begin
        occ = (tx_q[hc].size() > 31) ? 31 : tx_q[hc].size();
        case (hr)
          2'd0: n_host = {tx_q[hc].size() != 0, rx_q[hc].size() < DEPTH, ovr[hc], 5'(occ)};
          2'd1: n_host = (tx_q[hc].size() != 0) ? tx_q[hc][0] : 8'h00;
          2'd3: n_host = ID_EXP;
          default: n_host = 8'h00;
        endcase
      end
    end
    if (cpu_rd && cc >= 0 && cr == 2'd1) begin
      if (rx_q[cc].size() != 0) void'(rx_q[cc].pop_front());
      ovr[cc] = 1'b0;
    end
    if (host_rd && hc >= 0 && hr == 2'd1 && tx_q[hc].size() != 0) void'(tx_q[hc].pop_front());
    if (cpu_wr && cc >= 0 && !(cpu_byte && cpu_addr[0])) begin
      case (cr)
        2'd0: rie[cc] = cpu_wdata[6];
        2'd2: xie[cc] = cpu_wdata[6];
        2'd3: if (tx_q[cc].size() < DEPTH) tx_q[cc].push_back(cpu_wdata[7:0]);
        default: ;
      endcase
    end
    tx_fl = 1'b0;
    rx_fl = 1'b0;
    if (host_wr && hc >= 0) begin
      if (hr == 2'd0) begin
        tx_fl = host_wdata[0];
        rx_fl = host_wdata[1];
      end else if (hr == 2'd2) begin
        if (rx_q[hc].size() < DEPTH) rx_q[hc].push_back(host_wdata);
        else ovr[hc] = 1'b1;
      end
      if (tx_fl) tx_q[hc].delete();
      if (rx_fl) rx_q[hc].delete();
    end
    if (cpu_init) begin
      for (int n = 0; n < NCH; n++) begin
        tx_q[n].delete();
        rx_q[n].delete();
        rie[n] = 1'b0;
        xie[n] = 1'b0;
        ovr[n] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    exp_cpu_rdata  = n_cpu;
    exp_host_rdata = n_host;
    exp_rx_irq     = n_rxi;
    exp_tx_irq     = n_txi;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_byte = 1'b0; cpu_init = 1'b0;
    host_rd = 1'b0; host_wr = 1'b0;
  endtask

  task automatic cpu_write(input logic [21:0] a, input logic [15:0] d, input bit b = 1'b0);
    cpu_addr = a; cpu_wdata = d; cpu_byte = b; cpu_wr = 1'b1;
    step();
  endtask

  task automatic cpu_read(input logic [21:0] a);
    cpu_addr = a; cpu_rd = 1'b1;
    step();
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    host_addr = a; host_wdata = d; host_wr = 1'b1;
    step();
  endtask

  task automatic host_read(input logic [7:0] a);
    host_addr = a; host_rd = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_byte = 1'b0; cpu_init = 1'b0;
    cpu_wdata = '0; host_addr = '0; host_rd = 1'b0; host_wr = 1'b0; host_wdata = '0;
    exp_cpu_rdata = '0; exp_host_rdata = '0; exp_rx_irq = '0; exp_tx_irq = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_cpu_rdata", cpu_rdata, 16'h0000);
    chk("reset_host_rdata", 16'(host_rdata), 16'h0000);
    chk("reset_irq", 16'({rx_irq, tx_irq}), 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // 1: reset register values
    cpu_read(XCSR0);      chk("t1_xcsr", cpu_rdata, 16'h0080);
    host_read(8'h00);     chk("t1_stat", 16'(host_rdata), 16'h0040);
    host_read(8'h03);     chk("t1_id", 16'(host_rdata), 16'h0013);

    // 2: CPU -> host TX path
    cpu_write(XBUF0, 16'h0041);
    cpu_write(XBUF0, 16'h0042);
    cpu_write(XBUF0, 16'h0043);
    host_read(8'h00);     chk("t2_stat", 16'(host_rdata), 16'h00C3);
    host_read(8'h01);     chk("t2_tx0", 16'(host_rdata), 16'h0041);
    host_read(8'h01);     chk("t2_tx1", 16'(host_rdata), 16'h0042);
    host_read(8'h01);     chk("t2_tx2", 16'(host_rdata), 16'h0043);
    host_read(8'h01);     chk("t2_tx_empty", 16'(host_rdata), 16'h0000);

    // 3: RX overrun
    for (int i = 0; i < 9; i++) host_write(8'h02, 8'(8'h10 + i));
    host_read(8'h00);     chk("t3_stat", 16'(host_rdata), 16'h0020);
    cpu_read(RBUF0);      chk("t3_rbuf_ovr", cpu_rdata, 16'hC010);
    cpu_read(RBUF0);      chk("t3_rbuf_next", cpu_rdata, 16'h0011);
    for (int i = 0; i < 6; i++) cpu_read(RBUF0);
    chk("t3_rbuf_last", cpu_rdata, 16'h0017);
    cpu_read(RBUF0);      chk("t3_rbuf_empty", cpu_rdata, 16'h0000);

    // 4: receiver interrupt timing
    cpu_write(RCSR0, 16'h0040);
    host_write(8'h02, 8'h55);
    chk("t4_irq_not_yet", 16'(rx_irq), 16'h0000);
    step();
    chk("t4_irq_rise", 16'(rx_irq), 16'h0001);
    cpu_read(RBUF0);      chk("t4_rbuf", cpu_rdata, 16'h0055);
    step();
    chk("t4_irq_fall", 16'(rx_irq), 16'h0000);

    // 5: INIT with full TX and a colliding host RX write
    cpu_write(XCSR0, 16'h0040);
    step();
    chk("t5_tx_irq_on", 16'(tx_irq), 16'h0001);
    for (int i = 0; i < 8; i++) cpu_write(XBUF0, 16'(16'h00B0 + i));
    cpu_read(XCSR0);      chk("t5_xcsr_full", cpu_rdata, 16'h0040);
    cpu_init = 1'b1; host_addr = 8'h02; host_wdata = 8'h77; host_wr = 1'b1;
    step();
    step();
    chk("t5_tx_irq", 16'(tx_irq), 16'h0000);
    cpu_read(XCSR0);      chk("t5_xcsr", cpu_rdata, 16'h0080);
    cpu_read(RCSR0);      chk("t5_rcsr", cpu_rdata, 16'h0000);
    host_read(8'h00);     chk("t5_stat", 16'(host_rdata), 16'h0040);

    // full TX with same-cycle push and pop, then a dropped push
    for (int i = 0; i < 8; i++) cpu_write(XBUF0, 16'(16'h00A0 + i));
    host_read(8'h00);     chk("f_stat_full", 16'(host_rdata), 16'h00C8);
    cpu_addr = XBUF0; cpu_wdata = 16'h0099; cpu_wr = 1'b1; host_addr = 8'h01; host_rd = 1'b1;
    step();
    chk("f_pop_push", 16'(host_rdata), 16'h00A0);
    cpu_write(XBUF0, 16'h0077);
    host_read(8'h00);     chk("f_stat_still_full", 16'(host_rdata), 16'h00C8);
    for (int i = 0; i < 8; i++) host_read(8'h01);
    chk("f_last", 16'(host_rdata), 16'h0099);
    // empty pop with a same-cycle push: pop sees empty, push lands
    cpu_addr = XBUF0; cpu_wdata = 16'h003C; cpu_wr = 1'b1; host_addr = 8'h01; host_rd = 1'b1;
    step();
    chk("f_empty_pop", 16'(host_rdata), 16'h0000);
    host_read(8'h01);     chk("f_after_push", 16'(host_rdata), 16'h003C);
    // high-byte writes are ignored
    cpu_write(22'o17777567, 16'h4400, 1'b1);
    host_read(8'h00);     chk("f_hibyte_xbuf", 16'(host_rdata), 16'h0040);
    cpu_write(RCSR0, 16'h0040);
    cpu_write(22'o17777561, 16'h0000, 1'b1);
    cpu_read(RCSR0);      chk("f_hibyte_rcsr", cpu_rdata, 16'h0040);
    cpu_write(RCSR0, 16'h0000);
    // flush beats a same-cycle push
    cpu_addr = XBUF0; cpu_wdata = 16'h0011; cpu_wr = 1'b1; host_addr = 8'h00; host_wdata = 8'h01;
    host_wr = 1'b1;
    step();
    host_read(8'h00);     chk("f_flush_wins", 16'(host_rdata), 16'h0040);
    // full RX with same-cycle pop and push: no overrun
    for (int i = 0; i < 8; i++) host_write(8'h02, 8'(8'h20 + i));
    cpu_addr = RBUF0; cpu_rd = 1'b1; host_addr = 8'h02; host_wdata = 8'h30; host_wr = 1'b1;
    step();
    chk("f_rx_pop_push", cpu_rdata, 16'h0020);
    host_read(8'h00);     chk("f_rx_stat", 16'(host_rdata), 16'h0000);
    for (int i = 0; i < 8; i++) cpu_read(RBUF0);
    chk("f_rx_last", cpu_rdata, 16'h0030);

    // 6: channel independence and out-of-range host channel
    cpu_addr = XBUF1; cpu_wdata = 16'h005A; cpu_wr = 1'b1;
    host_addr = 8'h02; host_wdata = 8'h33; host_wr = 1'b1;
    step();
    host_read(8'h05);     chk("t6_ch1_tx", 16'(host_rdata), 16'h005A);
    cpu_addr = RBUF0; cpu_rd = 1'b1; host_addr = 8'h06; host_wdata = 8'h66; host_wr = 1'b1;
    step();
    chk("t6_ch0_rx", cpu_rdata, 16'h0033);
    cpu_read(RBUF1);      chk("t6_ch1_rx", cpu_rdata, 16'h0066);
    host_read(8'h04);     chk("t6_ch1_stat", 16'(host_rdata), 16'h0040);
    host_write(8'h0A, 8'hEE);
    host_read(8'h08);     chk("t6_ch2_stat", 16'(host_rdata), 16'h0000);
    cpu_read(RBUF0);      chk("t6_ch0_empty", cpu_rdata, 16'h0000);
    cpu_read(22'o17777570); chk("t6_nohit_rd", cpu_rdata, 16'h0000);
    chk("t6_nohit", 16'(cpu_hit), 16'h0000);
    step();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
